// File: rtl/qdiv_sched_pkg.sv
// -----------------------------------------------------------------------------
// qdiv_sched_pkg
// Shared types and default constants for the qdiv scheduler slice.
//   sched_state_t      : scheduler FSM state encoding
//   QDIV_Q_DEFAULT     : default fractional bits of the attached qdiv
//   QDIV_N_DEFAULT     : default total word width including sign
//   QDIV_NREQ_DEFAULT  : default number of requesters
// -----------------------------------------------------------------------------
package qdiv_sched_pkg;

  localparam int QDIV_Q_DEFAULT    = 8;
  localparam int QDIV_N_DEFAULT    = 16;
  localparam int QDIV_NREQ_DEFAULT = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT_LO = 3'd2,
    S_WAIT_HI = 3'd3,
    S_RESP    = 3'd4
  } sched_state_t;

endpackage

// File: rtl/qdiv_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin priority search. Starting at ptr_i and moving
// upward modulo NREQ, the first set bit of req_i wins.
//   req_i   : request vector
//   ptr_i   : index with highest priority this cycle
//   grant_o : one-hot grant (all zero when no request)
//   idx_o   : encoded index of the granted requester
//   any_o   : at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  always_comb begin
    int cand;
    // NOTE: every signal written here gets a default first, so no path through
    // the block can leave a value unassigned and infer a latch.
    cand    = 0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cand = (int'(ptr_i) + i) % NREQ;
      // Only the first hit along the rotated order is taken.
      if (!any_o && req_i[IW'(cand)]) begin
        any_o              = 1'b1;
        idx_o              = IW'(cand);
        grant_o[IW'(cand)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/qdiv_scheduler.sv
// -----------------------------------------------------------------------------
// qdiv_scheduler
// Shares one sequential fixed-point divider (qdiv) among NREQ requesters.
// Round-robin arbitration, one operation outstanding at a time; completion is
// tracked purely by the falling and rising edges of the divider's complete
// flag, so the divider latency may change without touching this block.
//
// Optional feature macro: QDIV_SCHED_DIVZERO_EN
//   defined   : divisors with magnitude bits all zero bypass the divider and
//               return a saturated quotient with overflow and divzero set.
//   undefined : every request goes to the divider, o_resp_divzero is 0.
//
// Ports
//   i_clk, i_rst             : clock, asynchronous active-high reset
//   i_req_valid              : per-requester request, held until ready seen
//   i_req_dividend/divisor   : packed operands, requester k at [k*N +: N]
//   o_req_ready              : one-hot accept strobe (combinational, 1 cycle)
//   o_resp_valid             : one-hot result strobe (1 cycle)
//   o_resp_quotient          : result quotient, valid with o_resp_valid
//   o_resp_overflow          : divider overflow for the result
//   o_resp_divzero           : divide-by-zero flag for the result
//   o_busy                   : high in every state except IDLE
//   o_div_dividend/divisor   : registered operands to qdiv
//   o_div_start              : one-cycle start strobe to qdiv
//   i_div_quotient           : qdiv quotient
//   i_div_complete           : qdiv done flag (level, high when idle)
//   i_div_overflow           : qdiv overflow
// -----------------------------------------------------------------------------
module qdiv_scheduler
  import qdiv_sched_pkg::*;
#(
  parameter int Q    = QDIV_Q_DEFAULT,
  parameter int N    = QDIV_N_DEFAULT,
  parameter int NREQ = QDIV_NREQ_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NREQ-1:0]   i_req_valid,
  input  logic [NREQ*N-1:0] i_req_dividend,
  input  logic [NREQ*N-1:0] i_req_divisor,
  output logic [NREQ-1:0]   o_req_ready,
  output logic [NREQ-1:0]   o_resp_valid,
  output logic [N-1:0]      o_resp_quotient,
  output logic              o_resp_overflow,
  output logic              o_resp_divzero,
  output logic              o_busy,
  output logic [N-1:0]      o_div_dividend,
  output logic [N-1:0]      o_div_divisor,
  output logic              o_div_start,
  input  logic [N-1:0]      i_div_quotient,
  input  logic              i_div_complete,
  input  logic              i_div_overflow
);

  localparam int IW = $clog2(NREQ);

  sched_state_t state_q, state_d;

  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   gnt_idx_q, gnt_idx_d;
  logic [N-1:0]    div_a_q, div_a_d;
  logic [N-1:0]    div_b_q, div_b_d;
  logic [N-1:0]    quot_q, quot_d;
  logic            ovf_q, ovf_d;

  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic            grant_fire;
  logic            take_dz;
  logic [N-1:0]    sel_a, sel_b;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req_i   (i_req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  // Operands of the arbitration winner (one-hot select).
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (arb_grant[k]) begin
        sel_a = i_req_dividend[k*N +: N];
        sel_b = i_req_divisor[k*N +: N];
      end
    end
  end

  // A grant also waits for the divider to be idle; after a reset in the middle
  // of an operation this holds off until the unreset qdiv has finished.
  assign grant_fire = (state_q == S_IDLE) && arb_any && i_div_complete;

`ifdef QDIV_SCHED_DIVZERO_EN
  logic         dz_q, dz_d;
  logic [N-1:0] dz_quot;

  // Only the magnitude bits are inspected, so the most negative value also
  // counts as a zero divisor.
  assign take_dz = grant_fire && (sel_b[N-2:0] == '0);
  // Saturate toward the sign of the true quotient.
  assign dz_quot = (sel_a[N-1] ^ sel_b[N-1]) ? {1'b1, {(N-2){1'b0}}, 1'b1}
                                             : {1'b0, {(N-1){1'b1}}};
  assign o_resp_divzero = dz_q;
`else
  assign take_dz        = 1'b0;
  assign o_resp_divzero = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and updates together.
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (grant_fire) state_d = take_dz ? S_RESP : S_ISSUE;
      S_ISSUE:   state_d = S_WAIT_LO;
      S_WAIT_LO: if (!i_div_complete) state_d = S_WAIT_HI;
      S_WAIT_HI: if (i_div_complete) state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    o_req_ready  = grant_fire ? arb_grant : '0;
    o_div_start  = (state_q == S_ISSUE);
    o_busy       = (state_q != S_IDLE);
    o_resp_valid = '0;
    if (state_q == S_RESP) o_resp_valid[gnt_idx_q] = 1'b1;
  end

  assign o_div_dividend  = div_a_q;
  assign o_div_divisor   = div_b_q;
  assign o_resp_quotient = quot_q;
  assign o_resp_overflow = ovf_q;

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    gnt_idx_d = gnt_idx_q;
    div_a_d   = div_a_q;
    div_b_d   = div_b_q;
    quot_d    = quot_q;
    ovf_d     = ovf_q;
`ifdef QDIV_SCHED_DIVZERO_EN
    dz_d      = dz_q;
`endif

    // Operands are latched at grant and held until the next grant, so the
    // requester is free to present new data from the following cycle.
    if (grant_fire) begin
      div_a_d   = sel_a;
      div_b_d   = sel_b;
      gnt_idx_d = arb_idx;
`ifdef QDIV_SCHED_DIVZERO_EN
      if (take_dz) begin
        quot_d = dz_quot;
        ovf_d  = 1'b1;
        dz_d   = 1'b1;
      end
`endif
    end

    if ((state_q == S_WAIT_HI) && i_div_complete) begin
      quot_d = i_div_quotient;
      ovf_d  = i_div_overflow;
`ifdef QDIV_SCHED_DIVZERO_EN
      dz_d   = 1'b0;
`endif
    end

    if (state_q == S_RESP) begin
      rr_ptr_d = (gnt_idx_q == IW'(NREQ - 1)) ? '0 : gnt_idx_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: the operand and result registers are reset as well, because they
    // drive module outputs directly and must read zero out of reset.
    if (i_rst) begin
      rr_ptr_q  <= '0;
      gnt_idx_q <= '0;
      div_a_q   <= '0;
      div_b_q   <= '0;
      quot_q    <= '0;
      ovf_q     <= 1'b0;
`ifdef QDIV_SCHED_DIVZERO_EN
      dz_q      <= 1'b0;
`endif
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      gnt_idx_q <= gnt_idx_d;
      div_a_q   <= div_a_d;
      div_b_q   <= div_b_d;
      quot_q    <= quot_d;
      ovf_q     <= ovf_d;
`ifdef QDIV_SCHED_DIVZERO_EN
      dz_q      <= dz_d;
`endif
    end
  end

endmodule
